imem_loader: RTL and testbench



---
 rtl/imem_loader.sv | 76 +++++++
 tb/tb_imem_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: streams a program into the instruction store and serves a registered 10-byte fetch window
module imem_loader #(
   parameter int MEM_BYTES = 1024,
   parameter int LEN_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_start,
   input  logic [63:0]      load_base,
   input  logic [LEN_W-1:0] load_len,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             load_busy,
   output logic             load_done,
   output logic             load_err,
   output logic             prog_valid,
   input  logic [63:0]      fetch_pc,
   output logic [79:0]      fetch_bytes,
   output logic             fetch_adr_err
);
   localparam int AW = $clog2(MEM_BYTES);
   localparam logic [63:0] mem_end = 64'(MEM_BYTES);
   typedef enum logic [1:0] {IDLE, LOAD, DONE, ERR} state_t;
   state_t state, state_next;
   logic [7:0] mem [MEM_BYTES];
   logic [AW-1:0] waddr;
   logic [LEN_W-1:0] remaining;
   logic [79:0] fetch_next;
   logic accept, range_bad, start;
   assign accept = in_valid && state == LOAD;
   assign start = load_start && state == IDLE;
   // 65-bit sum so a base near 2^64 cannot wrap into range
   assign range_bad = load_base >= mem_end ||
                      ({1'b0, load_base} + 65'(load_len)) > {1'b0, mem_end};
   assign in_ready  = state == LOAD;
   assign load_busy = state == LOAD;
   assign load_done = state == DONE;
   assign load_err  = state == ERR;
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (load_start) state_next = load_len == '0 ? DONE : range_bad ? ERR : LOAD;
         LOAD: if (accept && remaining == LEN_W'(1)) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prog_valid <= 1'b0;
         waddr      <= '0;
         remaining  <= '0;
      end else begin
         state      <= state_next;
         prog_valid <= start ? 1'b0 : state == DONE ? 1'b1 : prog_valid;
         waddr      <= start ? load_base[AW-1:0] : accept ? waddr + 1'b1 : waddr;
         remaining  <= start ? load_len : accept ? remaining - 1'b1 : remaining;
      end
   end
   always_ff @(posedge clk) if (accept) mem[waddr] <= in_data;
   for (genvar i = 0; i < 10; i++) begin : g_fetch
      logic [63:0] a;
      assign a = fetch_pc + 64'(i);
      assign fetch_next[8*i +: 8] = (fetch_pc < mem_end && a < mem_end) ? mem[a[AW-1:0]] : 8'h00;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_bytes   <= '0;
         fetch_adr_err <= 1'b0;
      end else begin
         fetch_bytes   <= fetch_next;
         fetch_adr_err <= fetch_pc >= mem_end;
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scenario tests for imem_loader; inputs change and outputs are sampled on falling edges
module tb_imem_loader;
   logic clk = 1'b0, rst_n = 1'b1, load_start = 1'b0, in_valid = 1'b0;
   logic [63:0] load_base = '0, fetch_pc = '0;
   logic [15:0] load_len = '0;
   logic [7:0] in_data = '0;
   logic in_ready, load_busy, load_done, load_err, prog_valid, fetch_adr_err;
   logic [79:0] fetch_bytes;
   int tests = 0, fails = 0;
   imem_loader dut (
      .clk(clk), .rst_n(rst_n), .load_start(load_start), .load_base(load_base),
      .load_len(load_len), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
      .prog_valid(prog_valid), .fetch_pc(fetch_pc), .fetch_bytes(fetch_bytes),
      .fetch_adr_err(fetch_adr_err)
   );
   always #5 clk = ~clk;
   task automatic start_load(input logic [63:0] base, input logic [15:0] len);
      load_base = base; load_len = len; load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
   endtask
   task automatic do_load(input logic [63:0] base, input logic [15:0] len, input logic [127:0] data);
      start_load(base, len);
      for (int i = 0; i < int'(len); i++) begin
         in_valid = 1'b1; in_data = data[8*i +: 8];
         @(negedge clk);
      end
      in_valid = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
      tests++; if (load_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", load_busy); end
      tests++; if ({load_done, load_err} !== 2'b00) begin fails++; $display("FAIL reset_pulses: got %b exp 00", {load_done, load_err}); end
      tests++; if (prog_valid !== 1'b0) begin fails++; $display("FAIL reset_prog_valid: got %b exp 0", prog_valid); end
      tests++; if ({fetch_adr_err, fetch_bytes} !== 81'h0) begin fails++; $display("FAIL reset_fetch: got %h exp 0", {fetch_adr_err, fetch_bytes}); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_load_fetch;
      logic [79:0] prog = 80'h0000_0000_0000_000A_F230;
      start_load(64'd0, 16'd10);
      tests++; if ({load_busy, in_ready} !== 2'b11) begin fails++; $display("FAIL load_busy_ready: got %b exp 11", {load_busy, in_ready}); end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = prog[8*i +: 8];
         @(negedge clk);
      end
      in_valid = 1'b0; fetch_pc = 64'd0;
      tests++; if ({load_done, in_ready, load_busy} !== 3'b100) begin fails++; $display("FAIL done_state: got %b exp 100", {load_done, in_ready, load_busy}); end
      @(negedge clk);
      tests++; if ({load_done, prog_valid} !== 2'b01) begin fails++; $display("FAIL after_done: got %b exp 01", {load_done, prog_valid}); end
      tests++; if (fetch_bytes[7:0] !== 8'h30 || fetch_bytes[15:8] !== 8'hF2) begin fails++; $display("FAIL fetch_icode_regs: got %h exp f230", fetch_bytes[15:0]); end
      tests++; if (fetch_bytes[79:16] !== 64'hA || fetch_adr_err !== 1'b0) begin fails++; $display("FAIL fetch_valc: got %h/%b exp a/0", fetch_bytes[79:16], fetch_adr_err); end
   endtask
   task automatic test_backpressure;
      logic [5:0] v = 6'b101001;
      logic [47:0] d = 48'hCC_11_BB_11_11_AA;
      do_load(64'd100, 16'd4, 128'h04030201);
      start_load(64'd100, 16'd3);
      for (int i = 0; i < 6; i++) begin
         tests++; if (load_done !== 1'b0) begin fails++; $display("FAIL bp_early_done: cycle %0d got %b exp 0", i, load_done); end
         in_valid = v[i]; in_data = d[8*i +: 8];
         @(negedge clk);
      end
      in_valid = 1'b1; in_data = 8'h99; fetch_pc = 64'd100;
      tests++; if ({load_done, in_ready} !== 2'b10) begin fails++; $display("FAIL bp_done: got %b exp 10", {load_done, in_ready}); end
      @(negedge clk);
      tests++; if ({in_ready, load_done, prog_valid} !== 3'b001) begin fails++; $display("FAIL bp_idle: got %b exp 001", {in_ready, load_done, prog_valid}); end
      in_valid = 1'b0;
      @(negedge clk);
      tests++; if (fetch_bytes[31:0] !== 32'h04CCBBAA) begin fails++; $display("FAIL bp_mem: got %h exp 04ccbbaa", fetch_bytes[31:0]); end
   endtask
   task automatic test_range_err;
      do_load(64'd1016, 16'd8, 128'h0807060504030201);
      start_load(64'd1020, 16'd8);
      in_valid = 1'b1; in_data = 8'hEE; fetch_pc = 64'd1016;
      tests++; if ({load_err, in_ready, prog_valid} !== 3'b100) begin fails++; $display("FAIL err_1020: got %b exp 100", {load_err, in_ready, prog_valid}); end
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if ({load_err, prog_valid} !== 2'b00) begin fails++; $display("FAIL err_after: got %b exp 00", {load_err, prog_valid}); end
      @(negedge clk);
      tests++; if (fetch_bytes !== 80'h0000_0807060504030201) begin fails++; $display("FAIL err_no_write: got %h exp 0000080706050403 0201", fetch_bytes); end
      start_load(64'd2048, 16'd1);
      tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL err_2048: got %b exp 1", load_err); end
      @(negedge clk);
      start_load(64'd0, 16'd0);
      tests++; if ({load_done, load_err, load_busy} !== 3'b100) begin fails++; $display("FAIL zero_len: got %b exp 100", {load_done, load_err, load_busy}); end
      @(negedge clk);
      start_load(64'd1023, 16'd1);
      tests++; if ({load_busy, load_err} !== 2'b10) begin fails++; $display("FAIL last_byte_fits: got %b exp 10", {load_busy, load_err}); end
      in_valid = 1'b1; in_data = 8'h08;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
   endtask
   task automatic test_edge_fetch;
      fetch_pc = 64'd1023;
      @(negedge clk);
      tests++; if ({fetch_adr_err, fetch_bytes} !== {1'b0, 80'h08}) begin fails++; $display("FAIL fetch_1023: got %h exp 08", {fetch_adr_err, fetch_bytes}); end
      fetch_pc = 64'd1024;
      @(negedge clk);
      tests++; if ({fetch_adr_err, fetch_bytes} !== {1'b1, 80'h0}) begin fails++; $display("FAIL fetch_1024: got %h exp 1 and 0", {fetch_adr_err, fetch_bytes}); end
      fetch_pc = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
      tests++; if ({fetch_adr_err, fetch_bytes} !== {1'b1, 80'h0}) begin fails++; $display("FAIL fetch_max: got %h exp 1 and 0", {fetch_adr_err, fetch_bytes}); end
   endtask
   task automatic test_rdw;
      fetch_pc = 64'd5;
      start_load(64'd5, 16'd1);
      in_valid = 1'b1; in_data = 8'h77;
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (fetch_bytes[7:0] !== 8'h00) begin fails++; $display("FAIL rdw_old: got %h exp 00", fetch_bytes[7:0]); end
      @(negedge clk);
      tests++; if (fetch_bytes[7:0] !== 8'h77) begin fails++; $display("FAIL rdw_new: got %h exp 77", fetch_bytes[7:0]); end
   endtask
   task automatic test_reset_mid_load;
      fetch_pc = 64'd0;
      start_load(64'd200, 16'd5);
      in_valid = 1'b1; in_data = 8'h5A;
      @(negedge clk);
      in_data = 8'hA5;
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++; if ({in_ready, load_busy, load_done, load_err, prog_valid} !== 5'b0) begin fails++; $display("FAIL mid_reset_ctrl: got %b exp 00000", {in_ready, load_busy, load_done, load_err, prog_valid}); end
      tests++; if ({fetch_adr_err, fetch_bytes} !== 81'h0) begin fails++; $display("FAIL mid_reset_fetch: got %h exp 0", {fetch_adr_err, fetch_bytes}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if ({load_busy, prog_valid} !== 2'b00) begin fails++; $display("FAIL post_reset_idle: got %b exp 00", {load_busy, prog_valid}); end
      start_load(64'd300, 16'd1);
      tests++; if (load_busy !== 1'b1) begin fails++; $display("FAIL post_reset_start: got %b exp 1", load_busy); end
      in_valid = 1'b1; in_data = 8'h42; fetch_pc = 64'd200;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      tests++; if ({fetch_bytes[15:0], prog_valid} !== {16'hA55A, 1'b1}) begin fails++; $display("FAIL mid_reset_mem: got %h/%b exp a55a/1", fetch_bytes[15:0], prog_valid); end
   endtask
   initial begin
      test_reset;
      test_load_fetch;
      test_backpressure;
      test_range_err;
      test_edge_fetch;
      test_rdw;
      test_reset_mid_load;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
